// File: rtl/ov7670_dvp_source.sv
// OV7670 DVP camera emulator: free-running p_clock plus framed RGB565
// test patterns on vsync/href/p_data, all updated on p_clock falls.
module ov7670_dvp_source #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BP        = 17,
   parameter int V_FP        = 10,
   parameter int PCLK_DIV    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_en,
   input  logic        cont_read,
   input  logic [1:0]  mode,
   input  logic [15:0] solid_rgb,
   output logic        p_clock,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  p_data,
   output logic        busy_o,
   output logic        frame_done_o
);

   localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
   localparam int CW = $clog2(LINE_LEN);
   localparam int M1 = (VSYNC_LINES > V_BP) ? VSYNC_LINES : V_BP;
   localparam int M2 = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
   localparam int MAXL = (M1 > M2) ? M1 : M2;
   localparam int LW = $clog2(MAXL + 1);
   localparam int DW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
   localparam int BAR_W = H_ACTIVE / 8;

   localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
   localparam logic [CW-1:0] ACT_COLS = CW'(2 * H_ACTIVE);
   localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      VBP,
      ACTIVE,
      VFP
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] col;
   logic [CW-1:0] col_n;
   logic [LW-1:0] line;
   logic [LW-1:0] line_n;
   logic [LW-1:0] line_last;
   logic          frame_go;
   logic          frame_end;

   logic [DW-1:0] div_cnt;
   logic          div_wrap;
   logic          fall_tick;

   logic          pend;
   logic [1:0]    mode_q;
   logic [15:0]   rgb_q;
   logic [15:0]   pix_cnt;

   logic [15:0]   xb;
   logic [5:0]    x6;
   logic [4:0]    y5;
   logic [2:0]    bar;
   logic [15:0]   pix_val;
   logic          act_n;
   logic [7:0]    byte_n;

   function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

   assign div_wrap  = (div_cnt == DIV_LAST);
   assign fall_tick = div_wrap & p_clock;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         p_clock <= 1'b0;
      end else if (div_wrap) begin
         div_cnt <= '0;
         p_clock <= ~p_clock;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_comb begin
      case (state)
         VSYNC:   line_last = LW'(VSYNC_LINES - 1);
         VBP:     line_last = LW'(V_BP - 1);
         ACTIVE:  line_last = LW'(V_ACTIVE - 1);
         VFP:     line_last = LW'(V_FP - 1);
         default: line_last = '0;
      endcase
   end

   always_comb begin
      state_n   = state;
      col_n     = col;
      line_n    = line;
      frame_go  = 1'b0;
      frame_end = 1'b0;
      if (state == IDLE) begin
         if (pend) begin
            state_n  = VSYNC;
            col_n    = '0;
            line_n   = '0;
            frame_go = 1'b1;
         end
      end else if (col != COL_LAST) begin
         col_n = col + 1'b1;
      end else begin
         col_n = '0;
         if (line != line_last) begin
            line_n = line + 1'b1;
         end else begin
            line_n = '0;
            case (state)
               VSYNC:  state_n = VBP;
               VBP:    state_n = ACTIVE;
               ACTIVE: state_n = VFP;
               VFP: begin
                  frame_end = 1'b1;
                  if (cont_read) begin
                     state_n  = VSYNC;
                     frame_go = 1'b1;
                  end else begin
                     state_n = IDLE;
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         col   <= '0;
         line  <= '0;
      end else if (fall_tick) begin
         state <= state_n;
         col   <= col_n;
         line  <= line_n;
      end
   end

   // Outputs are built from the position being entered, so they
   // change together with the counters on the same fall_tick.
   always_comb begin
      xb     = 16'(col_n >> 1);
      x6     = 6'(col_n >> 1);
      y5     = 5'(line_n);
      bar    = 3'(xb / 16'(BAR_W));
      act_n  = (state_n == ACTIVE) && (col_n < ACT_COLS);
      case (mode_q)
         2'd0:    pix_val = rgb_q;
         2'd1:    pix_val = bar_rgb(bar);
         2'd2:    pix_val = pix_cnt;
         default: pix_val = {y5, x6, y5};
      endcase
      byte_n = 8'h00;
      if (act_n) begin
         byte_n = col_n[0] ? pix_val[7:0] : pix_val[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend         <= 1'b0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         vsync        <= 1'b0;
         href         <= 1'b0;
         p_data       <= 8'h00;
         mode_q       <= 2'd0;
         rgb_q        <= 16'h0000;
         pix_cnt      <= 16'h0000;
      end else begin
         frame_done_o <= 1'b0;
         if (state == IDLE && start_en) begin
            pend <= 1'b1;
         end
         if (fall_tick) begin
            vsync  <= (state_n == VSYNC);
            href   <= act_n;
            p_data <= byte_n;
            if (frame_go) begin
               pend    <= 1'b0;
               busy_o  <= 1'b1;
               mode_q  <= mode;
               rgb_q   <= solid_rgb;
               pix_cnt <= 16'h0000;
            end else if (act_n && col_n[0]) begin
               pix_cnt <= pix_cnt + 16'h0001;
            end
            if (frame_end) begin
               frame_done_o <= 1'b1;
               if (!cont_read) begin
                  busy_o <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ov7670_dvp_source.sv
// Bench for ov7670_dvp_source: two instances (PCLK_DIV 1 and 2) checked
// every cycle against a frame-position model, plus scenario checks.
module tb_ov7670_dvp_source;

   localparam int HA = 8;
   localparam int VA = 4;
   localparam int HB = 4;
   localparam int VS = 1;
   localparam int VBP = 1;
   localparam int VFP = 1;
   localparam int LINE = 2 * HA + HB;
   localparam int FRAME = (VS + VBP + VA + VFP) * LINE;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst[2];
   logic        st_en[2];
   logic        cont[2];
   logic [1:0]  md[2];
   logic [15:0] rgb[2];
   logic        o_pc[2];
   logic        o_vs[2];
   logic        o_hr[2];
   logic [7:0]  o_pd[2];
   logic        o_busy[2];
   logic        o_fd[2];

   int total = 0;
   int bad = 0;

   ov7670_dvp_source #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
      .VSYNC_LINES(VS), .V_BP(VBP), .V_FP(VFP), .PCLK_DIV(1)
   ) u0 (
      .clk(clk), .reset(rst[0]), .start_en(st_en[0]),
      .cont_read(cont[0]), .mode(md[0]), .solid_rgb(rgb[0]),
      .p_clock(o_pc[0]), .vsync(o_vs[0]), .href(o_hr[0]),
      .p_data(o_pd[0]), .busy_o(o_busy[0]), .frame_done_o(o_fd[0])
   );

   ov7670_dvp_source #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
      .VSYNC_LINES(VS), .V_BP(VBP), .V_FP(VFP), .PCLK_DIV(2)
   ) u1 (
      .clk(clk), .reset(rst[1]), .start_en(st_en[1]),
      .cont_read(cont[1]), .mode(md[1]), .solid_rgb(rgb[1]),
      .p_clock(o_pc[1]), .vsync(o_vs[1]), .href(o_hr[1]),
      .p_data(o_pd[1]), .busy_o(o_busy[1]), .frame_done_o(o_fd[1])
   );

   function automatic int divof(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic logic [15:0] pix_of(input int r, input int x,
                                          input logic [1:0] m,
                                          input logic [15:0] c);
      logic [31:0] rr;
      logic [31:0] xx;
      logic [15:0] v;
      rr = r;
      xx = x;
      case (m)
         2'd0: v = c;
         2'd1: begin
            case (x / (HA / 8))
               0: v = 16'hFFFF;
               1: v = 16'hFFE0;
               2: v = 16'h07FF;
               3: v = 16'h07E0;
               4: v = 16'hF81F;
               5: v = 16'hF800;
               6: v = 16'h001F;
               default: v = 16'h0000;
            endcase
         end
         2'd2: v = 16'((r * HA + x) % 65536);
         default: v = {rr[4:0], xx[5:0], rr[4:0]};
      endcase
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Model: frame position in p_clock periods (-1 when idle).
   int          n[2] = '{0, 0};
   int          mp[2] = '{-1, -1};
   bit          mpend[2];
   bit          mbusy[2];
   bit          mdone[2];
   logic [1:0]  mmode[2];
   logic [15:0] mrgb[2];
   bit          fall_m;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            n[i] = 0;
            mp[i] = -1;
            mpend[i] = 0;
            mbusy[i] = 0;
            mdone[i] = 0;
         end else begin
            n[i]++;
            fall_m = (n[i] % (2 * divof(i)) == 0);
            mdone[i] = 0;
            if (mp[i] < 0) begin
               if (fall_m && mpend[i]) begin
                  mp[i] = 0;
                  mpend[i] = 0;
                  mbusy[i] = 1;
                  mmode[i] = md[i];
                  mrgb[i] = rgb[i];
               end else if (st_en[i]) begin
                  mpend[i] = 1;
               end
            end else if (fall_m) begin
               mp[i]++;
               if (mp[i] == FRAME) begin
                  mdone[i] = 1;
                  if (cont[i]) begin
                     mp[i] = 0;
                     mmode[i] = md[i];
                     mrgb[i] = rgb[i];
                  end else begin
                     mp[i] = -1;
                     mbusy[i] = 0;
                  end
               end
            end
         end
      end
   end

   int          e_pc;
   logic        e_vs;
   logic        e_hr;
   logic [7:0]  e_pd;
   logic [15:0] pv;
   int          ln;
   int          cl;
   int          rw;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         e_pc = (n[i] / divof(i)) % 2;
         e_vs = 1'b0;
         e_hr = 1'b0;
         e_pd = 8'h00;
         if (mp[i] >= 0) begin
            ln = mp[i] / LINE;
            cl = mp[i] % LINE;
            rw = ln - VS - VBP;
            e_vs = (ln < VS);
            e_hr = (rw >= 0) && (rw < VA) && (cl < 2 * HA);
            pv = pix_of(rw, cl / 2, mmode[i], mrgb[i]);
            if (e_hr) e_pd = (cl % 2 == 1) ? pv[7:0] : pv[15:8];
         end
         chk($sformatf("u%0d p_clock", i), o_pc[i], e_pc);
         chk($sformatf("u%0d vsync", i), o_vs[i], e_vs);
         chk($sformatf("u%0d href", i), o_hr[i], e_hr);
         chk($sformatf("u%0d p_data", i), o_pd[i], e_pd);
         chk($sformatf("u%0d busy_o", i), o_busy[i], mbusy[i]);
         chk($sformatf("u%0d frame_done_o", i), o_fd[i], mdone[i]);
      end
   end

   // Scenario monitor for u0.
   bit         mon_clr = 0;
   int         per_cnt, vs_per, vs_rises, href_pulses, done_cnt;
   int         done_at[$];
   int         vs_rise_at[$];
   bit         done_busy[$];
   logic [7:0] bytes[$];
   logic       pc_q = 0;
   logic       vs_q = 0;
   logic       hr_q = 0;

   always @(negedge clk) begin
      if (mon_clr) begin
         per_cnt = 0;
         vs_per = 0;
         vs_rises = 0;
         href_pulses = 0;
         done_cnt = 0;
         done_at.delete();
         vs_rise_at.delete();
         done_busy.delete();
         bytes.delete();
      end else begin
         if (o_pc[0] && !pc_q) begin
            per_cnt++;
            if (o_vs[0]) vs_per++;
            if (o_hr[0]) bytes.push_back(o_pd[0]);
         end
         if (o_hr[0] && !hr_q) href_pulses++;
         if (o_fd[0]) begin
            done_cnt++;
            done_at.push_back(per_cnt);
            done_busy.push_back(o_busy[0]);
         end
         if (o_vs[0] && !vs_q) begin
            vs_rises++;
            vs_rise_at.push_back(per_cnt);
            per_cnt = 0;
         end
      end
      pc_q = o_pc[0];
      vs_q = o_vs[0];
      hr_q = o_hr[0];
   end

   // Monitor for u1: p_clock period and data-edge discipline.
   int         cyc = 0;
   int         last_rise = 0;
   int         per2 = 0;
   logic [7:0] b2[$];
   logic       pc2_q = 0;
   logic [7:0] pd2_q = 8'h00;

   always @(negedge clk) begin
      cyc++;
      if (o_pc[1] && !pc2_q) begin
         per2 = cyc - last_rise;
         last_rise = cyc;
         if (o_hr[1]) b2.push_back(o_pd[1]);
      end
      if (o_pd[1] !== pd2_q) begin
         chk("u1 p_data change on p_clock fall", {30'd0, pc2_q, o_pc[1]}, 2);
      end
      pc2_q = o_pc[1];
      pd2_q = o_pd[1];
   end

   logic [7:0] bar_b[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF,
                             8'h07, 8'hE0, 8'hF8, 8'h1F, 8'hF8, 8'h00,
                             8'h00, 8'h1F, 8'h00, 8'h00};

   task automatic clr_mon();
      mon_clr = 1;
      @(negedge clk);
      @(negedge clk);
      mon_clr = 0;
   endtask

   task automatic pulse(input int i);
      @(negedge clk);
      st_en[i] = 1;
      @(negedge clk);
      st_en[i] = 0;
   endtask

   task automatic wait_cnt(input int which, input int target,
                           input int budget, input string nm);
      int k;
      int v;
      k = 0;
      forever begin
         v = (which == 0) ? done_cnt : (which == 1) ? vs_rises : href_pulses;
         if (v >= target) break;
         if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, count %0d want %0d", nm, v, target);
            break;
         end
         @(negedge clk);
         k++;
      end
   endtask

   task automatic wait_busy(input int i, input logic lvl, input int budget,
                            input string nm);
      int k;
      k = 0;
      while (o_busy[i] !== lvl) begin
         if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, busy_o %0b want %0b", nm, o_busy[i], lvl);
            break;
         end
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1;
         st_en[i] = 0;
         cont[i] = 0;
         md[i] = 0;
         rgb[i] = 0;
      end
      chk("model mode3 r2 x5", pix_of(2, 5, 2'd3, 16'h0), 16'h10A2);
      chk("model bar x3", pix_of(0, 3, 2'd1, 16'h0), 16'h07E0);
      chk("model cnt r1 x2", pix_of(1, 2, 2'd2, 16'h0), 16'h000A);

      repeat (5) begin
         @(negedge clk);
         chk("reset outputs", {o_pc[0], o_vs[0], o_hr[0], o_pd[0],
                               o_busy[0], o_fd[0]}, 0);
      end
      rst[0] = 0;
      rst[1] = 0;
      @(negedge clk);
      chk("first p_clock rise", o_pc[0], 1);
      @(negedge clk);
      chk("second p_clock fall", o_pc[0], 0);

      // Colour bars, single frame.
      clr_mon();
      md[0] = 2'd1;
      pulse(0);
      wait_cnt(0, 1, 1000, "bars done");
      wait_busy(0, 1'b0, 10, "bars idle");
      repeat (100) @(negedge clk);
      chk("bars vsync periods", vs_per, 20);
      chk("bars href pulses", href_pulses, 4);
      chk("bars done count", done_cnt, 1);
      if (done_at.size() > 0) chk("bars done period", done_at[0], 140);
      if (done_busy.size() > 0) chk("bars busy at done", done_busy[0], 0);
      chk("bars vsync rises", vs_rises, 1);
      chk("bars busy idle", o_busy[0], 0);
      chk("bars byte count", bytes.size(), 64);
      for (int j = 0; j < bytes.size() && j < 64; j++)
         chk($sformatf("bars byte %0d", j), bytes[j], bar_b[j % 16]);

      // Counter, continuous, with ignored mid-frame start/cont changes.
      clr_mon();
      md[0] = 2'd2;
      cont[0] = 1;
      pulse(0);
      wait_cnt(1, 1, 100, "cnt first vsync");
      repeat (60) @(negedge clk);
      pulse(0);
      cont[0] = 0;
      repeat (10) @(negedge clk);
      cont[0] = 1;
      wait_cnt(0, 2, 1500, "cnt two frames");
      repeat (40) @(negedge clk);
      cont[0] = 0;
      wait_cnt(0, 3, 1000, "cnt three frames");
      repeat (20) @(negedge clk);
      chk("cnt done count", done_cnt, 3);
      chk("cnt vsync rises", vs_rises, 3);
      if (vs_rise_at.size() == 3) begin
         chk("cnt vsync period 1", vs_rise_at[1], 140);
         chk("cnt vsync period 2", vs_rise_at[2], 140);
      end
      if (done_busy.size() == 3) begin
         chk("cnt busy at done 0", done_busy[0], 1);
         chk("cnt busy at done 1", done_busy[1], 1);
         chk("cnt busy at done 2", done_busy[2], 0);
      end
      chk("cnt busy idle", o_busy[0], 0);
      chk("cnt byte count", bytes.size(), 192);
      for (int j = 0; 2 * j + 1 < bytes.size() && j < 96; j++)
         chk($sformatf("cnt pixel %0d", j), {bytes[2*j], bytes[2*j+1]}, j % 32);

      // Reset during the second active line, then a clean frame.
      clr_mon();
      md[0] = 2'd3;
      pulse(0);
      wait_cnt(2, 2, 500, "row/col second line");
      repeat (3) @(negedge clk);
      rst[0] = 1;
      @(negedge clk);
      chk("mid reset outputs", {o_pc[0], o_vs[0], o_hr[0], o_pd[0],
                                o_busy[0], o_fd[0]}, 0);
      rst[0] = 0;
      clr_mon();
      pulse(0);
      wait_cnt(0, 1, 1000, "post reset done");
      chk("post reset href pulses", href_pulses, 4);
      chk("post reset byte count", bytes.size(), 64);
      if (bytes.size() >= 44)
         chk("post reset r2 x5", {bytes[42], bytes[43]}, 16'h10A2);

      // PCLK_DIV=2, row/col pattern.
      md[1] = 2'd3;
      pulse(1);
      wait_busy(1, 1'b1, 20, "u1 start");
      wait_busy(1, 1'b0, 2000, "u1 end");
      chk("u1 p_clock period", per2, 4);
      chk("u1 byte count", b2.size(), 64);
      if (b2.size() >= 44)
         chk("u1 r2 x5", {b2[42], b2[43]}, 16'h10A2);

      // Random traffic on both instances.
      repeat (3000) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            st_en[i] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) cont[i] = ~cont[i];
            if ($urandom_range(0, 99) == 0) begin
               md[i] = 2'($urandom);
               rgb[i] = 16'($urandom);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         st_en[i] = 0;
         cont[i] = 0;
      end
      wait_busy(0, 1'b0, 2000, "u0 final idle");
      wait_busy(1, 1'b0, 2000, "u1 final idle");
      repeat (10) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
